quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
Receive-side counterpart of the team's 2-bit up/down step generators. Watches a 2-bit Gray-coded quadrature pair (A/B) from an external encoder or a remote stepping source. Synchronizes the pair, decodes each legal transition as one up or down step, and accumulates a signed-agnostic wrapping position count. Flags illegal double-bit jumps. Sits between the board-level encoder pins and the control/status register block.

Parameters:
CNT_W, 16, width of position counter (>=2)
SYNC_STAGES, 2, flip-flop stages in input synchronizer (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; when 0, transitions are tracked but not counted
a_in  input  1  quadrature phase A, asynchronous to clk
b_in  input  1  quadrature phase B, asynchronous to clk
clr  input  1  synchronous position clear
err_clr  input  1  synchronous clear of sticky error
pos  output  CNT_W  accumulated position
dir  output  1  direction of last legal step: 1 = up, 0 = down
step  output  1  one-cycle pulse per counted legal step
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset (async, rst=1) values: pos=0, dir=0, step=0, err=0. Sync stages=0, prev=00, warm-up counter=0.
- Synchronizer: {a_in,b_in} passes through SYNC_STAGES registers. The final stage is cur[1:0] = {A,B}.
- Warm-up: for the first SYNC_STAGES+1 rising edges after rst deasserts, prev <= cur. No step, pos change, or err is produced. This prevents a spurious count when the pins rest at a nonzero code.
- Decode is evaluated every cycle after warm-up, comparing prev against cur; then prev <= cur unconditionally.
  - Up sequence: 00->01->11->10->00. This is STEP_UP: pos <= pos+1, dir <= 1, step <= 1.
  - Down sequence: 00->10->11->01->00. This is STEP_DN: pos <= pos-1, dir <= 0, step <= 1.
  - cur==prev: STEP_NONE. step <= 0, nothing else changes.
  - Two-bit change (00<->11, 01<->10): STEP_ERR. err <= 1, pos and dir unchanged, step <= 0.
- Latency: a pin change set up before rising edge N shows on pos/dir/step after edge N+SYNC_STAGES.
- Wrap-around: pos is modulo 2^CNT_W. All-ones + up gives 0. Zero + down gives all-ones. No saturation, no overflow flag.
- en=0: prev still tracks cur. step stays 0, pos and dir hold, err is not set. Re-enabling never counts a transition that happened while disabled.
- clr=1: pos <= 0 and overrides any same-cycle step to pos. dir and step still update normally. err is unaffected.
- err_clr=1: err <= 0, unless STEP_ERR occurs in the same cycle; set wins.
- Reset mid-operation: all state returns to reset values immediately, and warm-up restarts on deassertion.
- Maximum legal input rate: one Gray transition per SYNC_STAGES+1 clocks. Faster input may alias into STEP_ERR; this is by design.

Optional Feature:
QDEC_GLITCH_FILTER_EN
- Defined: a filter stage sits after the synchronizer. A new cur value is accepted for decode only after it holds identical for 3 consecutive clocks. Shorter pulses are discarded silently (no step, no err). Latency becomes N+SYNC_STAGES+2, and warm-up extends by 2 cycles.
- Undefined: no filter stage. Behaviour and latency are exactly as above.

Decomposition:
- Package qdec_pkg:
  - Gray code localparams: G0=00, G1=01, G2=11, G3=10.
  - Step-code enum: STEP_NONE, STEP_UP, STEP_DN, STEP_ERR.
  - Filter length constant: QDEC_FILT_LEN=3.
- Sub-module qdec_sync: a parameterized SYNC_STAGES-deep, 2-bit synchronizer with async reset to 0. Instantiated once.
- Decode table and counter stay in the top module.

Test Plan:
1. Reset release with pins at 11, held 10 cycles -> pos=0, step never asserted, err=0.
2. Four full up cycles (16 transitions, each held 4 clocks), en=1 -> pos=16, dir=1, 16 step pulses each 1 cycle wide, first pulse exactly SYNC_STAGES edges after the first pin change.
3. From pos=0, one down transition 00->10 -> pos=0xFFFF (CNT_W=16), dir=0. Then one up transition 10->00 -> pos=0.
4. Jump 01->10 -> err=1, pos unchanged. Assert err_clr together with a second illegal jump 00->11 -> err stays 1. err_clr alone next cycle -> err=0.
5. en=0 during 3 up transitions, then en=1 and 1 more up -> pos=1. Also assert clr in the same cycle as an up step at pos=7 -> pos=0, step=1, dir=1.
6. With QDEC_GLITCH_FILTER_EN: 2-clock pulse on a_in -> no step, no err. A 3-clock-stable transition -> step with latency SYNC_STAGES+2.

Source files
------------

// File: rtl/qdec_pkg.sv
// qdec_pkg: shared Gray codes, step codes and decode helper for the quadrature decoder.
package qdec_pkg;
  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b10;
  localparam int QDEC_FILT_LEN = 3;
  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ERR} step_t;
  function automatic logic [1:0] gidx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction
  // Position delta on the Gray ring: +1 up, -1 down, 2 is an illegal double-bit jump.
  function automatic step_t decode(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] d;
    d = gidx(c) - gidx(p);
    return d == 2'd0 ? STEP_NONE : d == 2'd1 ? STEP_UP : d == 2'd3 ? STEP_DN : STEP_ERR;
  endfunction
endpackage

// File: rtl/qdec_sync.sv
// qdec_sync: SYNC_STAGES-deep 2-bit synchronizer with async reset to 0.
module qdec_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  output logic [1:0] q
);
  logic [1:0] chain [SYNC_STAGES];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= 2'b00;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end
  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronizes an A/B quadrature pair, decodes Gray steps into a wrapping position.
// Optional QDEC_GLITCH_FILTER_EN adds a stability filter after the synchronizer.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err
);
  logic [1:0] raw, cur, prev;
  step_t code;
  qdec_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d({a_in, b_in}), .q(raw));
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int WARM = SYNC_STAGES + QDEC_FILT_LEN;
  logic [1:0] hist [QDEC_FILT_LEN-1];
  logic [1:0] held;
  logic       stable;
  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < QDEC_FILT_LEN - 1; i++) stable &= (hist[i] == raw);
  end
  assign cur = stable ? raw : held;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEC_FILT_LEN - 1; i++) hist[i] <= 2'b00;
      held <= 2'b00;
    end else begin
      hist[0] <= raw;
      for (int i = 1; i < QDEC_FILT_LEN - 1; i++) hist[i] <= hist[i-1];
      held <= cur;
    end
  end
`else
  localparam int WARM = SYNC_STAGES + 1;
  assign cur = raw;
`endif
  localparam int WW = $clog2(WARM + 1);
  logic [WW-1:0] wcnt;
  logic          warm;
  assign warm = (wcnt != WW'(WARM));
  // Warm-up lets prev settle on the resting pin code so it is never counted.
  always_comb code = (en && !warm) ? decode(prev, cur) : STEP_NONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      prev <= 2'b00;
      pos  <= '0;
      dir  <= 1'b0;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (warm) wcnt <= wcnt + 1'b1;
      prev <= cur;
      step <= (code == STEP_UP) || (code == STEP_DN);
      dir  <= (code == STEP_UP) ? 1'b1 : (code == STEP_DN) ? 1'b0 : dir;
      pos  <= clr ? '0 : (code == STEP_UP) ? pos + 1'b1 : (code == STEP_DN) ? pos - 1'b1 : pos;
      err  <= (code == STEP_ERR) ? 1'b1 : err_clr ? 1'b0 : err;
    end
  end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed self-checking bench for quad_step_decoder (CNT_W=16, SYNC_STAGES=2).
module tb_quad_step_decoder;
  localparam int S = 2;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = S + 2;
`else
  localparam int LAT = S;
`endif
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1, a_in = 1'b0, b_in = 1'b0, clr = 1'b0, err_clr = 1'b0;
  logic [15:0] pos;
  logic        dir, step, err;
  int          n_checks = 0, n_fail = 0;
  int          step_cnt = 0, wide_cnt = 0;
  logic        step_q = 1'b0;

  quad_step_decoder #(.CNT_W(16), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .clr(clr), .err_clr(err_clr),
    .pos(pos), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) begin
      step_cnt++;
      if (step_q) wide_cnt++;
    end
    step_q = (step === 1'b1);
  end

  task automatic drive(input logic [1:0] ab, input int hold);
    {a_in, b_in} = ab;
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
    {a_in, b_in} = ab;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    int c0;
    @(negedge clk);
    rst = 1'b1; {a_in, b_in} = 2'b11;
    repeat (2) @(negedge clk);
    n_checks++; if (pos !== 16'h0) begin n_fail++; $display("FAIL reset_pos: got %h want 0000", pos); end
    n_checks++; if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b want 0", dir); end
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    c0 = step_cnt;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (pos !== 16'h0) begin n_fail++; $display("FAIL warm_pos: got %h want 0000", pos); end
    n_checks++; if (step_cnt != c0) begin n_fail++; $display("FAIL warm_steps: got %0d want 0", step_cnt - c0); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL warm_err: got %b want 0", err); end
  endtask

  task automatic test_up;
    logic [1:0] seq [4];
    int c0, w0;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b00);
    c0 = step_cnt; w0 = wide_cnt;
    {a_in, b_in} = 2'b01;
    repeat (LAT) @(negedge clk);
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL up_early_step: got %b want 0", step); end
    @(negedge clk);
    n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL up_first_step: got %b want 1", step); end
    repeat (4 - LAT - 1 + 4) @(negedge clk);
    for (int i = 1; i < 16; i++) drive(seq[i % 4], 4);
    repeat (6) @(negedge clk);
    n_checks++; if (pos !== 16'd16) begin n_fail++; $display("FAIL up_pos: got %0d want 16", pos); end
    n_checks++; if (dir !== 1'b1) begin n_fail++; $display("FAIL up_dir: got %b want 1", dir); end
    n_checks++; if (step_cnt - c0 != 16) begin n_fail++; $display("FAIL up_pulses: got %0d want 16", step_cnt - c0); end
    n_checks++; if (wide_cnt != w0) begin n_fail++; $display("FAIL up_width: got %0d wide pulses want 0", wide_cnt - w0); end
  endtask

  task automatic test_wrap;
    do_reset(2'b00);
    drive(2'b10, 8);
    n_checks++; if (pos !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_down_pos: got %h want ffff", pos); end
    n_checks++; if (dir !== 1'b0) begin n_fail++; $display("FAIL wrap_down_dir: got %b want 0", dir); end
    drive(2'b00, 8);
    n_checks++; if (pos !== 16'h0000) begin n_fail++; $display("FAIL wrap_up_pos: got %h want 0000", pos); end
    n_checks++; if (dir !== 1'b1) begin n_fail++; $display("FAIL wrap_up_dir: got %b want 1", dir); end
  endtask

  task automatic test_err;
    do_reset(2'b00);
    drive(2'b01, 8);
    drive(2'b10, 8);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    n_checks++; if (pos !== 16'd1) begin n_fail++; $display("FAIL err_pos: got %0d want 1", pos); end
    drive(2'b00, 8);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr_alone: got %b want 0", err); end
    {a_in, b_in} = 2'b11;
    repeat (LAT) @(negedge clk);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", err); end
    n_checks++; if (pos !== 16'd2) begin n_fail++; $display("FAIL err_pos2: got %0d want 2", pos); end
    repeat (2) @(negedge clk);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr_final: got %b want 0", err); end
  endtask

  task automatic test_en_clr;
    int c0;
    do_reset(2'b00);
    c0 = step_cnt;
    en = 1'b0;
    drive(2'b01, 6); drive(2'b11, 6); drive(2'b10, 6);
    n_checks++; if (pos !== 16'd0 || step_cnt != c0) begin n_fail++; $display("FAIL en_off: pos %0d steps %0d want 0 0", pos, step_cnt - c0); end
    en = 1'b1;
    repeat (4) @(negedge clk);
    drive(2'b00, 8);
    n_checks++; if (pos !== 16'd1) begin n_fail++; $display("FAIL en_resume_pos: got %0d want 1", pos); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL en_err: got %b want 0", err); end
    drive(2'b01, 4); drive(2'b11, 4); drive(2'b10, 4); drive(2'b00, 4); drive(2'b01, 4); drive(2'b11, 8);
    n_checks++; if (pos !== 16'd7) begin n_fail++; $display("FAIL clr_pre_pos: got %0d want 7", pos); end
    {a_in, b_in} = 2'b10;
    repeat (LAT) @(negedge clk);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    n_checks++; if (pos !== 16'd0) begin n_fail++; $display("FAIL clr_pos: got %0d want 0", pos); end
    n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL clr_step: got %b want 1", step); end
    n_checks++; if (dir !== 1'b1) begin n_fail++; $display("FAIL clr_dir: got %b want 1", dir); end
    drive(2'b00, 8);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pos !== 16'd0 || dir !== 1'b0) begin n_fail++; $display("FAIL async_rst: pos %0d dir %b want 0 0", pos, dir); end
    @(negedge clk); rst = 1'b0;
  endtask

`ifdef QDEC_GLITCH_FILTER_EN
  task automatic test_glitch;
    int c0;
    do_reset(2'b00);
    c0 = step_cnt;
    drive(2'b10, 2);
    drive(2'b00, 10);
    n_checks++; if (step_cnt != c0 || err !== 1'b0 || pos !== 16'd0) begin n_fail++; $display("FAIL glitch_pulse: steps %0d err %b pos %0d want 0 0 0", step_cnt - c0, err, pos); end
    {a_in, b_in} = 2'b01;
    repeat (LAT) @(negedge clk);
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL glitch_early: got %b want 0", step); end
    @(negedge clk);
    n_checks++; if (step !== 1'b1 || pos !== 16'd1) begin n_fail++; $display("FAIL glitch_step: step %b pos %0d want 1 1", step, pos); end
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_up();
        test_wrap();
        test_err();
        test_en_clr();
`ifdef QDEC_GLITCH_FILTER_EN
        test_glitch();
`endif
      end
      begin
        #200000;
        n_checks++; n_fail++;
        $display("FAIL timeout: got no completion want completion within 200000");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
